// File: rtl/step_gen_pkg.sv
// Shared types and constants for the step pulse generator.
package step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } step_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : step_gen_pkg

// File: rtl/step_period_timer.sv
// Loadable phase counter that sets the spacing between step pulses.
// On load the counter starts at phase 1 (phase 0 belongs to the load cycle,
// whose pulse the parent raises directly); tick marks phase 0 of each period.
// A period of 0 behaves like a period of 1.
module step_period_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] phase;

  // Latch the period on load and wrap the phase at period-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= '0;
      phase    <= '0;
    end else if (load) begin
      period_q <= period;
      phase    <= (period <= DIV_W'(1)) ? '0 : DIV_W'(1);
    end else if (period_q <= DIV_W'(1) || phase == period_q - DIV_W'(1)) begin
      phase <= '0;
    end else begin
      phase <= phase + DIV_W'(1);
    end
  end

  assign tick = (phase == '0);

endmodule : step_period_timer

// File: rtl/step_pulse_gen.sv
// Step-command transmitter: accepts a request (direction, count, spacing)
// and emits that many single-cycle incr or decr pulses, one per period,
// followed by a one-cycle done strobe. All outputs are registered.
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_steps,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  output logic             incr,
  output logic             decr,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  step_state_t      state, state_next;
  logic             dir_q, dir_next;
  logic [CNT_W-1:0] remaining_next;
  logic             pulse;
  logic             incr_next, decr_next, done_next, ready_next;
  logic             accept;
  logic             tick;

  // req_ready is only ever high in IDLE, so it doubles as the state qualifier.
  assign accept = req_valid && req_ready;

  step_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .period (div),
    .tick   (tick)
  );

  // Next-state, pulse issue and remaining-count bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next     = state;
    dir_next       = dir_q;
    remaining_next = remaining;
    pulse          = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          dir_next = req_dir;
          if (req_steps == '0) begin
            state_next     = DONE;
            remaining_next = '0;
          end else begin
            // First pulse leaves on the accept edge itself.
            state_next     = RUN;
            pulse          = 1'b1;
            remaining_next = req_steps - CNT_W'(1);
          end
        end
      end
      RUN: begin
        // remaining==0 here means the last pulse is on the outputs now.
        if (abort || remaining == '0) begin
          state_next = DONE;
        end else if (tick) begin
          pulse          = 1'b1;
          remaining_next = remaining - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    incr_next  = pulse && (dir_next == DIR_UP);
    decr_next  = pulse && (dir_next == DIR_DOWN);
    done_next  = (state_next == DONE);
    ready_next = (state_next == IDLE);
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // values sampled before the edge, avoiding simulation order races.
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= DIR_DOWN;
      remaining <= '0;
      incr      <= 1'b0;
      decr      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_next;
      dir_q     <= dir_next;
      remaining <= remaining_next;
      incr      <= incr_next;
      decr      <= decr_next;
      done      <= done_next;
      req_ready <= ready_next;
    end
  end

endmodule : step_pulse_gen

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen. The reference model keeps only the
// accepted request (accept cycle, count, period, direction, completion cycle)
// and derives each cycle's expected outputs from the pulse timetable
// T+1+k*P with arithmetic.
module tb_step_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_dir;
  logic [3:0] req_steps;
  logic [7:0] div;
  logic       abort;
  logic       incr;
  logic       decr;
  logic       done;
  logic [3:0] remaining;

  step_pulse_gen #(
    .CNT_W (4),
    .DIV_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dir   (req_dir),
    .req_steps (req_steps),
    .div       (div),
    .abort     (abort),
    .incr      (incr),
    .decr      (decr),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  bit have_req   = 1'b0;
  bit dir_req    = 1'b0;
  int t_acc      = 0;
  int n_req      = 0;
  int p_req      = 1;
  int done_cyc   = 0;
  int prev_rem   = 0;
  int ready_from = 1 << 30;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit pulse_at(input int c);
    if (!have_req) return 1'b0;
    for (int k = 0; k < n_req; k++) begin
      int t = t_acc + 1 + k * p_req;
      if (t == c && t < done_cyc) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pulses_upto(input int c);
    int cnt = 0;
    for (int k = 0; k < n_req; k++) begin
      int t = t_acc + 1 + k * p_req;
      if (t <= c && t < done_cyc) cnt++;
    end
    return cnt;
  endfunction

  function automatic int exp_rem(input int c);
    if (!have_req) return 0;
    if (c <= t_acc) return prev_rem;
    return n_req - pulses_upto(c);
  endfunction

  function automatic bit exp_ready(input int c);
    return (c >= ready_from) && !(have_req && c <= done_cyc);
  endfunction

  // Drive one cycle of inputs, update the model, advance, compare outputs.
  task automatic step(input bit v, input bit d, input int s, input int dv,
                      input bit a, input bit r);
    req_valid = v;
    req_dir   = d;
    req_steps = 4'(s);
    div       = 8'(dv);
    abort     = a;
    rst_n     = r;
    if (r) begin
      if (a && have_req && cyc > t_acc && cyc < done_cyc) done_cyc = cyc + 1;
      if (v && exp_ready(cyc)) begin
        prev_rem = exp_rem(cyc);
        have_req = 1'b1;
        t_acc    = cyc;
        n_req    = s % 16;
        p_req    = (dv % 256 == 0) ? 1 : dv % 256;
        dir_req  = d;
        done_cyc = (n_req == 0) ? t_acc + 1 : t_acc + 2 + (n_req - 1) * p_req;
      end
    end else begin
      have_req   = 1'b0;
      ready_from = cyc + 2;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("incr",      incr,      pulse_at(cyc) &&  dir_req);
    check("decr",      decr,      pulse_at(cyc) && !dir_req);
    check("done",      done,      have_req && cyc == done_cyc);
    check("req_ready", req_ready, exp_ready(cyc));
    check("remaining", remaining, exp_rem(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    // Power-on reset: two cycles low, outputs checked at zero.
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Up, 3 steps, spacing 4.
    step(1'b1, 1'b1, 3, 4, 1'b0, 1'b1);
    idle(14);

    // Down, 4 steps, spacing 0 (treated as 1): consecutive pulses.
    step(1'b1, 1'b0, 4, 0, 1'b0, 1'b1);
    idle(6);

    // Zero steps: immediate done.
    step(1'b1, 1'b1, 0, 7, 1'b0, 1'b1);
    idle(3);

    // Abort in cycle T+8 of an up, 5 step, spacing 3 request.
    step(1'b1, 1'b1, 5, 3, 1'b0, 1'b1);
    idle(7);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    idle(4);

    // Abort while idle must be ignored.
    step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    idle(1);

    // Reset in cycle T+4 of an up, 5 step, spacing 2 request.
    step(1'b1, 1'b1, 5, 2, 1'b0, 1'b1);
    idle(3);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(4);

    // req_valid held high with fields changing every cycle.
    for (int i = 0; i < 60; i++)
      step(1'b1, 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, 1'b1);
    idle(3);

    // Randomised traffic with occasional aborts and resets.
    for (int i = 0; i < 800; i++) begin
      int s  = ($urandom % 4 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      int dv = ($urandom % 5 == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
      step(($urandom % 3) != 0, 1'($urandom), s, dv,
           ($urandom % 30) == 0, ($urandom % 150) != 0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_step_pulse_gen
